// File: rtl/gol_gen_scheduler.sv
// Game of Life generation scheduler: run/pause/step/speed controls turned into a
// gen_req/gen_done handshake. Define GOL_GEN_COUNT_EN to add the gen_count output.
module gol_gen_scheduler #(
  parameter int BASE_PERIOD = 50000000,
  parameter int SPEED_W     = 3,
  parameter int CNT_W       = 26,
  parameter int GEN_W       = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run_toggle,
  input  logic               step,
  input  logic               speed_up,
  input  logic               speed_down,
  input  logic               gen_done,
  output logic               gen_req,
  output logic               running,
  output logic [SPEED_W-1:0] speed
`ifdef GOL_GEN_COUNT_EN
  ,
  output logic [GEN_W-1:0]   gen_count
`endif
);

  localparam logic [1:0] PAUSED = 2'd0;
  localparam logic [1:0] COUNT  = 2'd1;
  localparam logic [1:0] BUSY   = 2'd2;

  localparam logic [31:0] BASE = 32'(BASE_PERIOD);

  logic [1:0]         state, state_next;
  logic               running_next;
  logic [CNT_W-1:0]   prescaler, prescaler_next;
  logic [SPEED_W-1:0] speed_next;
  logic [CNT_W-1:0]   limit;
  logic [31:0]        shifted;
  logic               done_accept;

  // Period shrinks by half per speed level, but never below one cycle.
  always_comb begin
    shifted = BASE >> speed;
    limit   = (shifted == 32'd0) ? '0 : CNT_W'(shifted - 32'd1);
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_next     = state;
    running_next   = running;
    prescaler_next = prescaler;
    speed_next     = speed;
    done_accept    = 1'b0;

    if (speed_up && !speed_down && speed != '1)
      speed_next = speed + 1'b1;
    else if (speed_down && !speed_up && speed != '0)
      speed_next = speed - 1'b1;

    case (state)
      PAUSED: begin
        if (run_toggle) begin
          state_next     = COUNT;
          running_next   = 1'b1;
          prescaler_next = '0;
        end else if (step) begin
          state_next = BUSY;
        end
      end
      COUNT: begin
        if (run_toggle) begin
          state_next     = PAUSED;
          running_next   = 1'b0;
          prescaler_next = '0;
        end else if (prescaler >= limit) begin
          // >= rather than == so a speed increase never lets the count run past the limit.
          state_next     = BUSY;
          prescaler_next = '0;
        end else begin
          prescaler_next = prescaler + 1'b1;
        end
      end
      BUSY: begin
        running_next = running ^ run_toggle;
        if (gen_done) begin
          done_accept    = 1'b1;
          state_next     = running_next ? COUNT : PAUSED;
          prescaler_next = '0;
        end
      end
      default: begin
        state_next     = PAUSED;
        running_next   = 1'b0;
        prescaler_next = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= PAUSED;
      running   <= 1'b0;
      gen_req   <= 1'b0;
      speed     <= '0;
      prescaler <= '0;
    end else begin
      state     <= state_next;
      running   <= running_next;
      gen_req   <= (state_next == BUSY);
      speed     <= speed_next;
      prescaler <= prescaler_next;
    end
  end

`ifdef GOL_GEN_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      gen_count <= '0;
    else if (done_accept)
      gen_count <= gen_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_gol_gen_scheduler.sv
// Self-checking bench for gol_gen_scheduler: directed scenarios plus random stimulus
// against a behavioural model. Honours GOL_GEN_COUNT_EN when defined.
module tb_gol_gen_scheduler;

  localparam int BP = 16;
  localparam int SW = 2;
  localparam int CW = 5;
  localparam int GW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          run_toggle, step, speed_up, speed_down, gen_done;
  logic          gen_req, running;
  logic [SW-1:0] speed;
`ifdef GOL_GEN_COUNT_EN
  logic [GW-1:0] gen_count;
`endif

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  gol_gen_scheduler #(
    .BASE_PERIOD(BP), .SPEED_W(SW), .CNT_W(CW), .GEN_W(GW)
  ) dut (
    .clk(clk), .reset(reset),
    .run_toggle(run_toggle), .step(step),
    .speed_up(speed_up), .speed_down(speed_down),
    .gen_done(gen_done),
    .gen_req(gen_req), .running(running), .speed(speed)
`ifdef GOL_GEN_COUNT_EN
    , .gen_count(gen_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the scheduler is fully described by "request outstanding",
  // "free-running", the speed level and the cycles elapsed since counting began.
  typedef struct {
    bit req;
    bit run;
    int spd;
    int elapsed;
    int gens;
  } model_t;

  model_t m;

  function automatic model_t model_next(model_t c, bit rt, bit st, bit su, bit sd, bit gd);
    model_t n = c;
    int per = BP >> c.spd;
    int lim = (per > 0 ? per : 1) - 1;
    if (su && !sd && c.spd < (1 << SW) - 1) n.spd = c.spd + 1;
    if (sd && !su && c.spd > 0)             n.spd = c.spd - 1;
    if (c.req) begin
      n.run = c.run ^ rt;
      if (gd) begin
        n.req     = 1'b0;
        n.elapsed = 0;
        n.gens    = (c.gens + 1) % (1 << GW);
      end
    end else if (c.run) begin
      if (rt) begin
        n.run     = 1'b0;
        n.elapsed = 0;
      end else if (c.elapsed >= lim) begin
        n.req     = 1'b1;
        n.elapsed = 0;
      end else begin
        n.elapsed = c.elapsed + 1;
      end
    end else if (rt) begin
      n.run     = 1'b1;
      n.elapsed = 0;
    end else if (st) begin
      n.req = 1'b1;
    end
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) m <= '{default: 0};
    else       m <= model_next(m, run_toggle, step, speed_up, speed_down, gen_done);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_gen_req", gen_req, int'(m.req));
      check("model_running", running, int'(m.run));
      check("model_speed", speed, m.spd);
`ifdef GOL_GEN_COUNT_EN
      check("model_gen_count", gen_count, m.gens);
`endif
    end
  end

  task automatic drive(input bit rt, input bit st, input bit su, input bit sd, input bit gd);
    run_toggle = rt; step = st; speed_up = su; speed_down = sd; gen_done = gd;
    @(negedge clk);
    run_toggle = 0; step = 0; speed_up = 0; speed_down = 0; gen_done = 0;
  endtask

  task automatic wait_req(output int edges);
    edges = 0;
    while (!gen_req && edges < 200) begin
      @(negedge clk);
      edges++;
    end
    if (!gen_req) edges = -1;
  endtask

  task automatic idle_check(input string name);
    int highs = 0;
    repeat (100) begin
      @(negedge clk);
      if (gen_req) highs++;
    end
    check(name, highs, 0);
  endtask

  initial begin
    int edges;
    reset = 1'b1;
    run_toggle = 0; step = 0; speed_up = 0; speed_down = 0; gen_done = 0;
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    cmp_en = 1'b1;

    check("rst_gen_req", gen_req, 0);
    check("rst_running", running, 0);
    check("rst_speed", speed, 0);

`ifdef GOL_GEN_COUNT_EN
    begin
      int exp_cnt[5] = '{1, 2, 3, 0, 1};
      for (int i = 0; i < 5; i++) begin
        drive(0, 1, 0, 0, 0);
        check("cnt_step_req", gen_req, 1);
        drive(0, 0, 0, 0, 1);
        check("cnt_seq", gen_count, exp_cnt[i]);
      end
    end
`endif

    // Free-running at speed 0: 16 edges from COUNT entry to request.
    drive(1, 0, 0, 0, 0);
    check("run_running", running, 1);
    wait_req(edges);
    check("run_first_req_edges", edges, 16);
    repeat (2) @(negedge clk);
    drive(0, 0, 0, 0, 1);
    check("run_done_req_low", gen_req, 0);
    wait_req(edges);
    check("run_second_req_edges", edges, 16);

    // Pause while busy: request held, then no new request.
    drive(1, 0, 0, 0, 0);
    check("busy_toggle_req_held", gen_req, 1);
    check("busy_toggle_running", running, 0);
    drive(0, 0, 0, 0, 1);
    check("busy_toggle_req_low", gen_req, 0);
    idle_check("busy_toggle_idle");

    // Single step while paused.
    drive(0, 1, 0, 0, 0);
    check("step_req", gen_req, 1);
    drive(0, 0, 0, 0, 1);
    check("step_running", running, 0);
    idle_check("step_idle");

    // Speed saturation and fastest period.
    repeat (4) drive(0, 0, 1, 0, 0);
    check("speed_sat_hi", speed, 3);
    drive(1, 0, 0, 0, 0);
    wait_req(edges);
    check("speed3_req_edges", edges, 2);
    drive(0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0);
    check("speed3_paused", running, 0);
    repeat (5) drive(0, 0, 0, 1, 0);
    check("speed_sat_lo", speed, 0);
    drive(0, 0, 1, 1, 0);
    check("speed_both_at0", speed, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 1, 0);
    check("speed_both_at1", speed, 1);
    drive(0, 0, 0, 1, 0);
    check("speed_back0", speed, 0);

    // Speed-up while the prescaler is already past the new limit.
    drive(1, 0, 0, 0, 0);
    repeat (10) @(negedge clk);
    drive(0, 0, 1, 0, 0);
    check("late_speed_no_req", gen_req, 0);
    check("late_speed_level", speed, 1);
    @(negedge clk);
    check("late_speed_req", gen_req, 1);
    drive(0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0);

`ifdef GOL_GEN_COUNT_EN
    // Asynchronous reset in the middle of a request.
    drive(0, 1, 0, 0, 0);
    check("pre_reset_req", gen_req, 1);
    #3 reset = 1'b1;
    #1;
    check("async_rst_req", gen_req, 0);
    check("async_rst_count", gen_count, 0);
    @(negedge clk);
    reset = 1'b0;
`endif

    repeat (3000) begin
      run_toggle = ($urandom_range(99) < 3);
      step       = ($urandom_range(99) < 5);
      speed_up   = ($urandom_range(99) < 5);
      speed_down = ($urandom_range(99) < 5);
      gen_done   = m.req ? ($urandom_range(99) < 30) : ($urandom_range(99) < 2);
      @(negedge clk);
    end
    run_toggle = 0; step = 0; speed_up = 0; speed_down = 0; gen_done = 0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
